uart_tx: RTL and testbench

- UART transmitter; the transmit-side counterpart of the Rx sample-clock generator and receiver.
- Serialises one byte per frame: start bit, 8 data bits LSB first, then STOP_BITS stop bits.
- Contains its own bit-period timer derived from sys_clk; no external baud clock.
- Sits between the host-side byte source (valid/ready handshake) and the serial TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_baud_gen.sv | 39 +++
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
//   uart_state_t   - transmitter FSM states
//   UART_DATA_BITS - payload bits per frame
//   bit_cycles()   - sys_clk cycles per line bit (truncating division)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int bit_cycles(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: bit-period timer for the UART transmitter.
// Counts 0..BIT_CYCLES-1 and wraps; bit_done is high for the single cycle
// in which the counter holds its last value.
// Ports:
//   sys_clk  - system clock
//   reset    - asynchronous active-high reset
//   clear    - synchronous restart of the bit period (frame start)
//   bit_done - one-cycle pulse at the end of every bit period
module uart_tx_baud_gen
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int BAUD_RATE    = 19200
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int BIT_CYCLES = bit_cycles(SYS_CLK_FREQ, BAUD_RATE);
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (clear || (bit_cnt == CNT_LAST)) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign bit_done = (bit_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends start bit, 8 data bits LSB first,
// optional parity bit, then STOP_BITS stop bits. Bit timing comes from an
// internal divider of sys_clk.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD = 1).
// Ports:
//   sys_clk  - system clock
//   reset    - asynchronous active-high reset
//   tx_data  - byte to send, sampled on handshake
//   tx_valid - tx_data is valid
//   tx_ready - transmitter idle, byte will be accepted
//   tx_out   - serial line, idles high
//   tx_busy  - frame in progress
//
// state  | meaning
// IDLE   | line high, waiting for tx_valid
// START  | line low for one bit period
// DATA   | shifting out data bits LSB first, bit_idx 0..7
// PARITY | parity bit for one bit period (UART_TX_PARITY_EN only)
// STOP   | line high for STOP_BITS bit periods, bit_idx counts stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_t state;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        bit_done;
    logic        handshake;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign tx_ready  = (state == IDLE);
    assign handshake = tx_valid && tx_ready;

    // Restarting the divider at the handshake aligns every bit period to the
    // start bit, independent of where the free-running count was.
    uart_tx_baud_gen #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE)
    ) u_baud_gen (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .clear    (handshake),
        .bit_done (bit_done)
    );

    // tx_out and tx_busy are loaded with the value for the state being
    // entered, so they change on the same edge as the state itself.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_valid) begin
                        shift   <= tx_data;
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                        state   <= START;
                        tx_out  <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state  <= DATA;
                        tx_out <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift <= shift >> 1;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            tx_out <= parity_bit;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_out  <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at 1 MHz / 100 kbaud
// (10 cycles per bit). A frame-level model predicts tx_out, tx_busy and
// tx_ready every cycle; directed scenarios pin the model with literals.
module tb_uart_tx;

    localparam int CLK_F = 1_000_000;
    localparam int BAUD  = 100_000;
    localparam int BC    = 10;
`ifdef UART_TX_PARITY_EN
    localparam int STOP  = 2;
    localparam int PAR   = 1;
`else
    localparam int STOP  = 1;
    localparam int PAR   = 0;
`endif
    localparam int PODD  = 0;
    localparam int FRAME = (9 + PAR + STOP) * BC;

    logic       sys_clk  = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;

    always #5 sys_clk = ~sys_clk;

    uart_tx #(
        .SYS_CLK_FREQ (CLK_F),
        .BAUD_RATE    (BAUD),
        .STOP_BITS    (STOP),
        .PARITY_ODD   (PODD)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int         rem = 0;           // cycles left in current frame, 0 = idle
    logic [7:0] cur = 8'h00;
    logic       exp_out = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_ready = 1'b1;
    int         model_frames = 0;

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[3'(k - 1)];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return (^d) ^ (PODD != 0);
`endif
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge sys_clk or posedge reset);
            if (reset) begin
                rem = 0;
            end else if (rem > 0) begin
                rem--;
            end else if (tx_valid) begin
                cur = tx_data;
                rem = FRAME;
                model_frames++;
            end
            if (rem > 0) begin
                exp_out   = frame_bit(cur, (FRAME - rem) / BC);
                exp_busy  = 1'b1;
                exp_ready = 1'b0;
            end else begin
                exp_out   = 1'b1;
                exp_busy  = 1'b0;
                exp_ready = 1'b1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!reset) begin
            check_bit("model_tx_out", tx_out, exp_out);
            check_bit("model_tx_busy", tx_busy, exp_busy);
            check_bit("model_tx_ready", tx_ready, exp_ready);
        end
    end

    // ---------------- directed helpers ----------------
    logic line_s [0:399];
    logic rdy_s  [0:399];
    logic busy_s [0:399];

    task automatic start_byte(input logic [7:0] b);
        @(negedge sys_clk);
        tx_valid = 1'b1;
        tx_data  = b;
    endtask

    // Sample index i is frame cycle i when started right after start_byte.
    task automatic run_capture(input int n, input int drop_idx, input int inj_idx,
                               input logic [7:0] inj_data, input logic [7:0] next_data);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            line_s[i] = tx_out;
            rdy_s[i]  = tx_ready;
            busy_s[i] = tx_busy;
            if (i == 0) tx_data = next_data;
            if (i == drop_idx) tx_valid = 1'b0;
            if (i == inj_idx) begin
                tx_valid = 1'b1;
                tx_data  = inj_data;
            end
            if (i == inj_idx + 1) tx_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [9:0] seq_a5;
        logic [7:0] lit;
        int cnt;
        int rises;
        int dut_frames;
        int model_start;
        logic prev_busy;

        // 1: reset and idle line
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        #1;
        check_bit("reset_tx_out", tx_out, 1'b1);
        check_bit("reset_tx_busy", tx_busy, 1'b0);
        check_bit("reset_tx_ready", tx_ready, 1'b1);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (tx_out === 1'b1) cnt++;
        end
        check_int("idle_high_cycles", cnt, 50);

        // 2: 0xA5 frame
`ifdef UART_TX_PARITY_EN
        seq_a5 = 10'b0101001010;
`else
        seq_a5 = 10'b1101001010;
`endif
        start_byte(8'hA5);
        run_capture(FRAME + 10, 0, -10, 8'h00, 8'h5C);
        for (int b = 0; b < 10; b++) begin
            cnt = 0;
            for (int j = 0; j < BC; j++) if (line_s[b*BC + j] === seq_a5[b]) cnt++;
            check_int($sformatf("a5_bit%0d_cycles", b), cnt, 10);
        end
        cnt = 0;
        for (int i = 0; i < FRAME + 10; i++) if (rdy_s[i] === 1'b0) cnt++;
`ifdef UART_TX_PARITY_EN
        check_int("a5_ready_low", cnt, 120);
`else
        check_int("a5_ready_low", cnt, 100);
`endif

        // 3: back-to-back 0x00 then 0xFF with tx_valid held high
        start_byte(8'h00);
        run_capture(2*FRAME + 20, FRAME + 1, -10, 8'h00, 8'hFF);
        for (int k = 0; k < 8; k++)
            check_bit($sformatf("b2b_f1_bit%0d", k), line_s[15 + 10*k], 1'b0);
        cnt = 0;
        for (int i = 90 + 10*PAR; i < 2*FRAME + 20; i++) begin
            if (line_s[i] !== 1'b1) break;
            cnt++;
        end
`ifdef UART_TX_PARITY_EN
        check_int("b2b_gap_high", cnt, 21);
`else
        check_int("b2b_gap_high", cnt, 11);
`endif
        check_bit("b2b_idle_one_cycle_before", rdy_s[FRAME-1], 1'b0);
        check_bit("b2b_idle_one_cycle", rdy_s[FRAME], 1'b1);
        check_bit("b2b_idle_one_cycle_after", rdy_s[FRAME+1], 1'b0);
        check_bit("b2b_f2_start", line_s[FRAME + 5], 1'b0);
        for (int k = 1; k <= 8; k++)
            check_bit($sformatf("b2b_f2_bit%0d", k-1), line_s[FRAME + 1 + 10*k + 5], 1'b1);
        check_bit("b2b_f2_stop", line_s[FRAME + 1 + 90 + 10*PAR + 5], 1'b1);

        // 4: tx_valid during a frame is ignored
        lit = 8'h3C;
        start_byte(8'h3C);
        run_capture(FRAME + 40, 0, 30, 8'hFF, 8'h81);
        for (int k = 0; k < 8; k++)
            check_bit($sformatf("ign_bit%0d", k), line_s[15 + 10*k], lit[k]);
        rises = 0;
        for (int i = 1; i < FRAME + 40; i++) if (busy_s[i] === 1'b1 && busy_s[i-1] === 1'b0) rises++;
        check_int("ign_extra_frames", rises, 0);
        check_bit("ign_idle_after", busy_s[FRAME + 30], 1'b0);

        // 5: reset mid-frame
        start_byte(8'h00);
        run_capture(35, 0, -10, 8'h00, 8'h00);
        check_bit("rst_line_low_before", line_s[34], 1'b0);
        @(negedge sys_clk);
        #2;
        reset = 1'b1;
        #1;
        check_bit("rst_async_tx_out", tx_out, 1'b1);
        check_bit("rst_async_tx_busy", tx_busy, 1'b0);
        check_bit("rst_async_tx_ready", tx_ready, 1'b1);
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        lit = 8'h5A;
        start_byte(8'h5A);
        run_capture(FRAME + 5, 0, -10, 8'h00, 8'h00);
        check_bit("rst_next_start", line_s[5], 1'b0);
        for (int k = 0; k < 8; k++)
            check_bit($sformatf("rst_next_bit%0d", k), line_s[15 + 10*k], lit[k]);

        // 6: 0x07 frame tail (parity bit when enabled)
        start_byte(8'h07);
        run_capture(FRAME + 10, 0, -10, 8'h00, 8'h00);
        check_bit("p07_bit7", line_s[85], 1'b0);
`ifdef UART_TX_PARITY_EN
        cnt = 0;
        for (int i = 90; i < 120; i++) if (line_s[i] === 1'b1) cnt++;
        check_int("p07_parity_and_stop_high", cnt, 30);
        check_bit("p07_ready_low_119", rdy_s[119], 1'b0);
        check_bit("p07_ready_back_120", rdy_s[120], 1'b1);
`else
        check_bit("p07_ready_low_99", rdy_s[99], 1'b0);
        check_bit("p07_ready_back_100", rdy_s[100], 1'b1);
`endif

        // randomized traffic, checked every cycle by the model
        model_start = model_frames;
        dut_frames  = 0;
        prev_busy   = tx_busy;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if (tx_busy === 1'b1 && prev_busy === 1'b0) dut_frames++;
            prev_busy = tx_busy;
            tx_valid = ($urandom_range(0, 5) == 0);
            tx_data  = 8'($urandom);
        end
        tx_valid = 1'b0;
        repeat (FRAME + 5) begin
            @(negedge sys_clk);
            if (tx_busy === 1'b1 && prev_busy === 1'b0) dut_frames++;
            prev_busy = tx_busy;
        end
        check_int("random_frame_count", dut_frames, model_frames - model_start);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
